// File: rtl/mips_mem_bridge_if.sv
// Avalon-style memory bus between mips_mem_bridge (master) and the memory slave.
interface mips_mem_bridge_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_mem_bridge.sv
// Bridges one MIPS multicycle load/store into one Avalon-style bus transfer.
// Define MEM_BRIDGE_ALIGN_CHECK_EN to reject misaligned accesses instead of truncating the address.
module mips_mem_bridge #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic        core_signed,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_misalign,
    output logic        core_buserr,
    mips_mem_bridge_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] tcnt;
    logic        ld_we;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  ld_off;
    logic        reject;
    logic        timeout_hit;
    logic [1:0]  off;
    logic [3:0]  be_nxt;
    logic [31:0] wd_nxt;
    logic [31:0] lane;
    logic [31:0] ext;

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    assign reject = (core_size == 2'b01 && core_addr[0]) ||
                    (core_size[1] && core_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            core_misalign <= 1'b0;
        else if (state == IDLE && core_req && reject)
            core_misalign <= 1'b1;
        else if (state == RESP)
            core_misalign <= 1'b0;
    end
`else
    assign reject        = 1'b0;
    assign core_misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1));
    assign core_done   = (state == RESP);
    assign core_stall  = reset && ((state == IDLE && core_req) || state == ACCESS);

    // Lane selection ignores the low address bits a size cannot use.
    always_comb begin
        off    = 2'b00;
        be_nxt = 4'b1111;
        wd_nxt = core_wdata;
        case (core_size)
            2'b00: begin
                off    = core_addr[1:0];
                be_nxt = 4'b0001 << core_addr[1:0];
                wd_nxt = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                off    = {core_addr[1], 1'b0};
                be_nxt = core_addr[1] ? 4'b1100 : 4'b0011;
                wd_nxt = {2{core_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = bus.readdata >> {ld_off, 3'b000};
        case (ld_size)
            2'b00:   ext = {{24{ld_signed & lane[7]}}, lane[7:0]};
            2'b01:   ext = {{16{ld_signed & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (core_req) state_nxt = reject ? RESP : ACCESS;
            ACCESS:  if (!bus.waitrequest || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.address    <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.writedata  <= '0;
            bus.byteenable <= '0;
            core_rdata     <= '0;
            core_buserr    <= 1'b0;
            tcnt           <= '0;
            ld_we          <= 1'b0;
            ld_size        <= 2'b00;
            ld_signed      <= 1'b0;
            ld_off         <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req && !reject) begin
                        bus.address    <= {core_addr[31:2], 2'b00};
                        bus.read       <= !core_we;
                        bus.write      <= core_we;
                        bus.writedata  <= wd_nxt;
                        bus.byteenable <= be_nxt;
                        tcnt           <= '0;
                        ld_we          <= core_we;
                        ld_size        <= core_size;
                        ld_signed      <= core_signed;
                        ld_off         <= off;
                    end
                end
                ACCESS: begin
                    if (!bus.waitrequest) begin
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        if (!ld_we)
                            core_rdata <= ext;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                        if (timeout_hit) begin
                            bus.read    <= 1'b0;
                            bus.write   <= 1'b0;
                            core_buserr <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Response flags and load data only live for the done cycle.
                    core_rdata  <= '0;
                    core_buserr <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed table-driven bench for mips_mem_bridge (built with TIMEOUT=4).
module tb_mips_mem_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [1:0]  core_size = 2'b00;
    logic        core_signed = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_stall;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        core_misalign;
    logic        core_buserr;

    int checks = 0;
    int errors = 0;

    mips_mem_bridge_if bus();

    mips_mem_bridge #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_size    (core_size),
        .core_signed  (core_signed),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_stall   (core_stall),
        .core_done    (core_done),
        .core_rdata   (core_rdata),
        .core_misalign(core_misalign),
        .core_buserr  (core_buserr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        core_req    = 1'b1;
        core_we     = we;
        core_size   = size;
        core_signed = sgn;
        core_addr   = addr;
        core_wdata  = wdata;
    endtask

    // Zero-wait access: request in cycle 0, strobe in cycle 1, done in cycle 2.
    task automatic run_vec(input vec_t v);
        drive(v.we, v.size, v.sgn, v.addr, v.wdata);
        bus.waitrequest = 1'b0;
        bus.readdata    = v.rd;
        @(negedge clk);
        check("c0_stall", 32'(core_stall), 32'd1);
        check("c0_read", 32'(bus.read), 32'd0);
        tick();
        @(negedge clk);
        check("c1_read", 32'(bus.read), 32'(!v.we));
        check("c1_write", 32'(bus.write), 32'(v.we));
        check("c1_addr", bus.address, v.exp_addr);
        check("c1_be", 32'(bus.byteenable), 32'(v.exp_be));
        check("c1_wd", bus.writedata, v.exp_wd);
        check("c1_stall", 32'(core_stall), 32'd1);
        check("c1_done", 32'(core_done), 32'd0);
        tick();
        core_req = 1'b0;
        @(negedge clk);
        check("c2_done", 32'(core_done), 32'd1);
        check("c2_rdata", core_rdata, v.exp_rdata);
        check("c2_stall", 32'(core_stall), 32'd0);
        check("c2_strobe", {30'd0, bus.read, bus.write}, 32'd0);
        check("c2_flags", {30'd0, core_buserr, core_misalign}, 32'd0);
        tick();
        @(negedge clk);
        check("c3_done", 32'(core_done), 32'd0);
        tick();
    endtask

    initial begin
        int ndone;
        vec_t mis;

        //            we size  sgn addr          wdata         rd            exp_addr      be     exp_wd        exp_rdata
        vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'hF, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h80FF_FFFF, 32'h0000_0200, 4'h8, 32'h0,        32'hFFFF_FF80};
        vecs[2] = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_FFFF, 32'h0000_0200, 4'h8, 32'h0,        32'h0000_0080};
        vecs[3] = '{1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'h8001_1234, 32'h0000_0200, 4'hC, 32'h0,        32'hFFFF_8001};
        vecs[4] = '{1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,        32'h8001_F234, 32'h0000_0200, 4'h3, 32'h0,        32'h0000_F234};
        vecs[5] = '{1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h1234_56A5, 32'h5555_5555, 32'h0000_0300, 4'h2, 32'hA5A5_A5A5, 32'h0};
        vecs[6] = '{1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'h5555_5555, 32'h0000_0400, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[7] = '{1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0,        32'h0000_7F00, 32'h0000_0200, 4'h2, 32'h0,        32'h0000_007F};
        vecs[8] = '{1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0,        32'h1122_3344, 32'h0000_0010, 4'hF, 32'h0,        32'h1122_3344};

        bus.waitrequest = 1'b0;
        bus.readdata    = '0;

        // Reset state, with a pending request that must not raise stall.
        core_req = 1'b1;
        #12;
        check("rst_addr", bus.address, 32'h0);
        check("rst_strobe", {30'd0, bus.read, bus.write}, 32'd0);
        check("rst_wd", bus.writedata, 32'h0);
        check("rst_be", 32'(bus.byteenable), 32'd0);
        check("rst_core", {27'd0, core_done, core_stall, core_misalign, core_buserr, 1'b0}, 32'd0);
        check("rst_rdata", core_rdata, 32'h0);
        core_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i]);

        // Half store held stable through three waitrequest cycles.
        drive(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
        bus.waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) bus.waitrequest = 1'b0;
            @(negedge clk);
            check("ws_write", 32'(bus.write), 32'd1);
            check("ws_addr", bus.address, 32'h0000_0100);
            check("ws_wd", bus.writedata, 32'hABCD_ABCD);
            check("ws_be", 32'(bus.byteenable), 32'hC);
            check("ws_done", 32'(core_done), 32'd0);
        end
        tick();
        core_req = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (core_done) ndone++;
            tick();
        end
        check("ws_done_count", 32'(ndone), 32'd1);

        // Misaligned word load.
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        bus.readdata = 32'hA1B2_C3D4;
        tick();
        core_req = 1'b0;
        @(negedge clk);
        check("mis_read", 32'(bus.read), 32'd0);
        check("mis_done", 32'(core_done), 32'd1);
        check("mis_flag", 32'(core_misalign), 32'd1);
        check("mis_rdata", core_rdata, 32'h0);
        tick();
        @(negedge clk);
        check("mis_after", {30'd0, core_done, core_misalign}, 32'd0);
        check("mis_read2", 32'(bus.read), 32'd0);
        tick();
`else
        mis = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'hA1B2_C3D4, 32'h0000_0100, 4'hF, 32'h0, 32'hA1B2_C3D4};
        run_vec(mis);
        mis = '{1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0000_BEEF, 32'h0, 32'h0000_0100, 4'hC, 32'hBEEF_BEEF, 32'h0};
        run_vec(mis);
`endif

        // Timeout abort with waitrequest stuck high.
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        bus.waitrequest = 1'b1;
        bus.readdata    = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            check("to_read", 32'(bus.read), 32'd1);
            check("to_done", 32'(core_done), 32'd0);
        end
        tick();
        core_req = 1'b0;
        @(negedge clk);
        check("to_read_drop", 32'(bus.read), 32'd0);
        check("to_done_pulse", 32'(core_done), 32'd1);
        check("to_buserr", 32'(core_buserr), 32'd1);
        check("to_rdata", core_rdata, 32'h0);
        tick();
        @(negedge clk);
        check("to_after", {30'd0, core_done, core_buserr}, 32'd0);
        tick();
        bus.waitrequest = 1'b0;

        // Reset asserted mid-access.
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0);
        bus.waitrequest = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("ra_read_before", 32'(bus.read), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("ra_strobe", {30'd0, bus.read, bus.write}, 32'd0);
        check("ra_be", 32'(bus.byteenable), 32'd0);
        check("ra_stall", 32'(core_stall), 32'd0);
        check("ra_done", 32'(core_done), 32'd0);
        core_req = 1'b0;
        bus.waitrequest = 1'b0;
        tick();
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (core_done) ndone++;
            tick();
        end
        check("ra_no_done", 32'(ndone), 32'd0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
